// File: rtl/biriscv_issue_scheduler.sv
// Dual-slot issue controller: picks which decode FIFO slots to pop using pairing rules
// and a small result scoreboard, then registers the issued instructions per pipe.
module biriscv_issue_scheduler #(
  parameter int SUPPORT_DUAL_ISSUE = 1,
  parameter int LOAD_LAT           = 2,
  parameter int MUL_LAT            = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        slot0_valid_i,
  input  logic [31:0] slot0_instr_i,
  input  logic [31:0] slot0_pc_i,
  input  logic [7:0]  slot0_class_i,
  input  logic        slot1_valid_i,
  input  logic [31:0] slot1_instr_i,
  input  logic [31:0] slot1_pc_i,
  input  logic [7:0]  slot1_class_i,
  input  logic        div_complete_i,
  output logic        slot0_pop_o,
  output logic        slot1_pop_o,
  output logic        issue0_valid_o,
  output logic [31:0] issue0_instr_o,
  output logic [31:0] issue0_pc_o,
  output logic [7:0]  issue0_class_o,
  output logic        issue1_valid_o,
  output logic [31:0] issue1_instr_o,
  output logic [31:0] issue1_pc_o,
  output logic [7:0]  issue1_class_o,
  output logic        div_busy_o
);

  localparam int C_INVALID = 7;
  localparam int C_LSU     = 5;
  localparam int C_BRANCH  = 4;
  localparam int C_MUL     = 3;
  localparam int C_DIV     = 2;
  localparam int C_CSR     = 1;
  localparam int C_RDV     = 0;

  logic [1:0] cnt [32];
  logic       div_busy;
  logic [4:0] div_rd;

  logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  logic       hazard0, hazard1, pair_legal, issue0, issue1, dual;

  assign rd0   = slot0_instr_i[11:7];
  assign rs1_0 = slot0_instr_i[19:15];
  assign rs2_0 = slot0_instr_i[24:20];
  assign rd1   = slot1_instr_i[11:7];
  assign rs1_1 = slot1_instr_i[19:15];
  assign rs2_1 = slot1_instr_i[24:20];

  function automatic logic reg_busy(input logic [4:0] r);
    return (r != 5'd0) && ((cnt[r] != 2'd0) || (div_busy && (div_rd == r)));
  endfunction

  always_comb begin
    hazard0 = (slot0_class_i[C_DIV] & div_busy) | reg_busy(rs1_0) | reg_busy(rs2_0) |
              reg_busy(rd0);
    hazard1 = (slot1_class_i[C_DIV] & div_busy) | reg_busy(rs1_1) | reg_busy(rs2_1) |
              reg_busy(rd1);
  end

  // Slot1 may only join slot0 when it neither depends on nor overwrites slot0's result.
  always_comb begin
    pair_legal = ~(slot0_class_i[C_CSR] | slot0_class_i[C_DIV] | slot0_class_i[C_INVALID] |
                   slot0_class_i[C_BRANCH]) &
                 ~(slot1_class_i[C_CSR] | slot1_class_i[C_DIV] | slot1_class_i[C_INVALID]) &
                 ~(slot0_class_i[C_LSU] & slot1_class_i[C_LSU]) &
                 ~(slot0_class_i[C_MUL] & slot1_class_i[C_MUL]);
    if (slot0_class_i[C_RDV] && (rd0 != 5'd0) &&
        ((rs1_1 == rd0) || (rs2_1 == rd0) || (rd1 == rd0)))
      pair_legal = 1'b0;
  end

  assign issue0 = slot0_valid_i & ~hazard0 & ~stall_i & ~flush_i;
  assign issue1 = slot1_valid_i & ~hazard1 & ~stall_i & ~flush_i &
                  (~slot0_valid_i | (issue0 & (SUPPORT_DUAL_ISSUE != 0) & pair_legal));
  assign dual   = issue0 & issue1;

  assign slot0_pop_o = issue0;
  assign slot1_pop_o = issue1;
  assign div_busy_o  = div_busy;

  // Counters age every cycle; a same-cycle issue reloads its rd (slot1 written last).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
      div_busy <= 1'b0;
      div_rd   <= 5'd0;
    end else begin
      for (int i = 1; i < 32; i++)
        if (cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
      if (div_complete_i) div_busy <= 1'b0;
      if (issue0) begin
        if (slot0_class_i[C_LSU] && slot0_class_i[C_RDV] && rd0 != 5'd0)
          cnt[rd0] <= 2'(LOAD_LAT);
        if (slot0_class_i[C_MUL] && rd0 != 5'd0) cnt[rd0] <= 2'(MUL_LAT);
        if (slot0_class_i[C_DIV]) begin
          div_busy <= 1'b1;
          div_rd   <= rd0;
        end
      end
      if (issue1) begin
        if (slot1_class_i[C_LSU] && slot1_class_i[C_RDV] && rd1 != 5'd0)
          cnt[rd1] <= 2'(LOAD_LAT);
        if (slot1_class_i[C_MUL] && rd1 != 5'd0) cnt[rd1] <= 2'(MUL_LAT);
        if (slot1_class_i[C_DIV]) begin
          div_busy <= 1'b1;
          div_rd   <= rd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue0_valid_o <= 1'b0;
      issue0_instr_o <= 32'd0;
      issue0_pc_o    <= 32'd0;
      issue0_class_o <= 8'd0;
      issue1_valid_o <= 1'b0;
      issue1_instr_o <= 32'd0;
      issue1_pc_o    <= 32'd0;
      issue1_class_o <= 8'd0;
    end else if (flush_i) begin
      issue0_valid_o <= 1'b0;
      issue1_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (issue0) begin
        issue0_valid_o <= 1'b1;
        issue0_instr_o <= slot0_instr_i;
        issue0_pc_o    <= slot0_pc_i;
        issue0_class_o <= slot0_class_i;
      end else if (issue1) begin
        issue0_valid_o <= 1'b1;
        issue0_instr_o <= slot1_instr_i;
        issue0_pc_o    <= slot1_pc_i;
        issue0_class_o <= slot1_class_i;
      end else begin
        issue0_valid_o <= 1'b0;
        issue0_instr_o <= 32'd0;
        issue0_pc_o    <= 32'd0;
        issue0_class_o <= 8'd0;
      end
      if (dual) begin
        issue1_valid_o <= 1'b1;
        issue1_instr_o <= slot1_instr_i;
        issue1_pc_o    <= slot1_pc_i;
        issue1_class_o <= slot1_class_i;
      end else begin
        issue1_valid_o <= 1'b0;
        issue1_instr_o <= 32'd0;
        issue1_pc_o    <= 32'd0;
        issue1_class_o <= 8'd0;
      end
    end
  end

endmodule
